// File: rtl/img_bank_sched_if.sv
// Pixel-in, BRAM-write, engine-dispatch and overflow signals of the ping-pong tile scheduler.
// Valid/ready: a pixel is taken on every cycle pix_valid=1 (no backpressure); proc_start is only raised while proc_ready=1.
interface img_bank_sched_if;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        bram_wren;
    logic        bram_wrbank;
    logic [13:0] bram_wraddr;
    logic [7:0]  bram_wrdata;
    logic        proc_ready;
    logic        proc_start;
    logic        proc_bank;
    logic [14:0] proc_len;
    logic        proc_last;
    logic        proc_done;
    logic        ovf_sticky;
    logic        ovf_clr;
    logic [1:0]  dbg_bank0_st;
    logic [1:0]  dbg_bank1_st;
    logic        dbg_wr_own;

    modport slave (
        input  pix_valid, pix_data, proc_ready, proc_done, ovf_clr,
        output bram_wren, bram_wrbank, bram_wraddr, bram_wrdata,
               proc_start, proc_bank, proc_len, proc_last, ovf_sticky,
               dbg_bank0_st, dbg_bank1_st, dbg_wr_own
    );

    modport master (
        output pix_valid, pix_data, proc_ready, proc_done, ovf_clr,
        input  bram_wren, bram_wrbank, bram_wraddr, bram_wrdata,
               proc_start, proc_bank, proc_len, proc_last, ovf_sticky,
               dbg_bank0_st, dbg_bank1_st, dbg_wr_own
    );
endinterface

// File: rtl/img_bank_sched.sv
// Two-bank tile scheduler: fills one image bank with incoming pixels while the other
// is processed by the enhancement engine; tiles with no free bank are dropped.
module img_bank_sched #(
    parameter int TILE_PIX  = 16384,
    parameter int FRAME_PIX = 360960
) (
    input  logic            s_axi_aclk,
    input  logic            s_axi_areset,
    img_bank_sched_if.slave bus
);
    typedef enum logic [1:0] {
        B_EMPTY   = 2'd0,
        B_FILLING = 2'd1,
        B_FULL    = 2'd2,
        B_BUSY    = 2'd3
    } bank_st_t;

    localparam logic [13:0] TILE_LAST  = 14'(TILE_PIX - 1);
    localparam logic [18:0] FRAME_LAST = 19'(FRAME_PIX - 1);

    bank_st_t    r_bank_st [2];
    logic [14:0] r_len [2];
    logic        r_last [2];
    logic        r_first_full;
    logic        r_own;
    logic        r_own_bank;
    logic [13:0] r_tcnt;
    logic [18:0] r_fcnt;
    logic        r_inflight;
    logic        r_inflight_bank;

    logic        r_wren;
    logic        r_wrbank;
    logic [13:0] r_wraddr;
    logic [7:0]  r_wrdata;
    logic        r_start;
    logic        r_pbank;
    logic [14:0] r_plen;
    logic        r_plast;
    logic        r_ovf;

    bank_st_t    w_bank_nxt [2];
    logic [14:0] w_len_nxt [2];
    logic        w_last_nxt [2];
    logic        w_first_nxt;
    logic        w_own_nxt;
    logic        w_own_bank_nxt;
    logic        w_done;
    logic        w_tile_start;
    logic        w_tile_end;
    logic        w_frame_end;
    logic        w_claim_ok;
    logic        w_claim_bank;
    logic        w_wbank;
    logic        w_write;
    logic        w_drop;
    logic        w_disp;
    logic        w_disp_bank;

    always_comb begin
        w_bank_nxt     = r_bank_st;
        w_len_nxt      = r_len;
        w_last_nxt     = r_last;
        w_first_nxt    = r_first_full;
        w_own_nxt      = r_own;
        w_own_bank_nxt = r_own_bank;

        // A finishing tile frees its bank before the claim below looks at it.
        w_done = bus.proc_done && r_inflight;
        if (w_done) begin
            w_bank_nxt[r_inflight_bank] = B_EMPTY;
        end

        w_tile_start = (r_tcnt == 14'd0);
        w_frame_end  = (r_fcnt == FRAME_LAST);
        w_tile_end   = bus.pix_valid && ((r_tcnt == TILE_LAST) || w_frame_end);
        w_claim_ok   = (w_bank_nxt[0] == B_EMPTY) || (w_bank_nxt[1] == B_EMPTY);
        w_claim_bank = (w_bank_nxt[0] != B_EMPTY);
        w_wbank      = w_tile_start ? w_claim_bank : r_own_bank;
        w_write      = bus.pix_valid && (w_tile_start ? w_claim_ok : r_own);
        w_drop       = bus.pix_valid && !w_write;

        if (w_write) begin
            if (w_tile_end) begin
                w_bank_nxt[w_wbank] = B_FULL;
                w_len_nxt[w_wbank]  = {1'b0, r_tcnt} + 15'd1;
                w_last_nxt[w_wbank] = w_frame_end;
                w_first_nxt         = (r_bank_st[~w_wbank] == B_FULL) ? ~w_wbank : w_wbank;
                w_own_nxt           = 1'b0;
            end else begin
                w_bank_nxt[w_wbank] = B_FILLING;
                w_own_nxt           = 1'b1;
                w_own_bank_nxt      = w_wbank;
            end
        end else if (w_drop) begin
            w_own_nxt = 1'b0;
        end

        // The dispatched bank is FULL, so it can never be the bank being written above.
        w_disp      = !r_inflight && bus.proc_ready &&
                      ((r_bank_st[0] == B_FULL) || (r_bank_st[1] == B_FULL));
        w_disp_bank = ((r_bank_st[0] == B_FULL) && (r_bank_st[1] == B_FULL)) ?
                      r_first_full : (r_bank_st[1] == B_FULL);
        if (w_disp) begin
            w_bank_nxt[w_disp_bank] = B_BUSY;
        end
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_bank_st[0]    <= B_EMPTY;
            r_bank_st[1]    <= B_EMPTY;
            r_len[0]        <= 15'd0;
            r_len[1]        <= 15'd0;
            r_last[0]       <= 1'b0;
            r_last[1]       <= 1'b0;
            r_first_full    <= 1'b0;
            r_own           <= 1'b0;
            r_own_bank      <= 1'b0;
            r_tcnt          <= 14'd0;
            r_fcnt          <= 19'd0;
            r_inflight      <= 1'b0;
            r_inflight_bank <= 1'b0;
            r_wren          <= 1'b0;
            r_wrbank        <= 1'b0;
            r_wraddr        <= 14'd0;
            r_wrdata        <= 8'd0;
            r_start         <= 1'b0;
            r_pbank         <= 1'b0;
            r_plen          <= 15'd0;
            r_plast         <= 1'b0;
            r_ovf           <= 1'b0;
        end else begin
            r_bank_st    <= w_bank_nxt;
            r_len        <= w_len_nxt;
            r_last       <= w_last_nxt;
            r_first_full <= w_first_nxt;
            r_own        <= w_own_nxt;
            r_own_bank   <= w_own_bank_nxt;

            if (bus.pix_valid) begin
                r_tcnt <= w_tile_end ? 14'd0 : r_tcnt + 14'd1;
                r_fcnt <= w_frame_end ? 19'd0 : r_fcnt + 19'd1;
            end

            r_wren <= w_write;
            if (w_write) begin
                r_wrbank <= w_wbank;
                r_wraddr <= r_tcnt;
                r_wrdata <= bus.pix_data;
            end

            r_start <= w_disp;
            if (w_disp) begin
                r_pbank         <= w_disp_bank;
                r_plen          <= r_len[w_disp_bank];
                r_plast         <= r_last[w_disp_bank];
                r_inflight      <= 1'b1;
                r_inflight_bank <= w_disp_bank;
            end else if (w_done) begin
                r_inflight <= 1'b0;
            end

            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.bram_wren    = r_wren;
    assign bus.bram_wrbank  = r_wrbank;
    assign bus.bram_wraddr  = r_wraddr;
    assign bus.bram_wrdata  = r_wrdata;
    assign bus.proc_start   = r_start;
    assign bus.proc_bank    = r_pbank;
    assign bus.proc_len     = r_plen;
    assign bus.proc_last    = r_plast;
    assign bus.ovf_sticky   = r_ovf;
    assign bus.dbg_bank0_st = r_bank_st[0];
    assign bus.dbg_bank1_st = r_bank_st[1];
    assign bus.dbg_wr_own   = r_own;
endmodule

// File: tb/tb_img_bank_sched.sv
// Bench for img_bank_sched with a 64-pixel tile and a 336-pixel frame (5 full tiles + one 16-pixel tile).
// Stimulus pushes expected BRAM writes and dispatches into queues; a negedge monitor pops and compares.
module tb_img_bank_sched;
  localparam int TILE  = 64;
  localparam int FRAME = 336;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  img_bank_sched_if bus();

  logic eng_done = 1'b0;
  logic man_done = 1'b0;
  assign bus.proc_done = eng_done | man_done;

  img_bank_sched #(.TILE_PIX(TILE), .FRAME_PIX(FRAME)) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (rst),
    .bus          (bus)
  );

  logic [22:0] wr_q[$];
  logic [16:0] disp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  bit eng_auto = 1'b0;
  int eng_lat = 10;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- engine model ----------------
  always begin
    @(negedge clk);
    if (!rst && eng_auto && bus.proc_start) begin
      repeat (eng_lat) @(posedge clk);
      #1 eng_done = 1'b1;
      @(posedge clk);
      #1 eng_done = 1'b0;
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [22:0] wexp;
  logic [16:0] dexp;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.bram_wren) begin
        if (wr_q.size() == 0) begin
          check("wr_unexpected", 32'(bus.bram_wren), 32'd0);
        end else begin
          wexp = wr_q.pop_front();
          check("wr_bank", 32'(bus.bram_wrbank), 32'(wexp[22]));
          check("wr_addr", 32'(bus.bram_wraddr), 32'(wexp[21:8]));
          check("wr_data", 32'(bus.bram_wrdata), 32'(wexp[7:0]));
        end
      end
      if (bus.proc_start) begin
        if (disp_q.size() == 0) begin
          check("disp_unexpected", 32'(bus.proc_start), 32'd0);
        end else begin
          dexp = disp_q.pop_front();
          check("disp_bank", 32'(bus.proc_bank), 32'(dexp[16]));
          check("disp_len", 32'(bus.proc_len), 32'(dexp[15:1]));
          check("disp_last", 32'(bus.proc_last), 32'(dexp[0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.pix_valid = 1'b0;
      bus.ovf_clr = 1'b0;
      man_done = 1'b0;
    end
  endtask

  // bank < 0 means the tile is expected to be dropped (no writes).
  task automatic send_tile(input int n, input int bank, input int seed, input bit done_first);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      d = 8'(seed * 13 + i);
      bus.pix_valid = 1'b1;
      bus.pix_data = d;
      man_done = done_first && (i == 0);
      if (bank >= 0) wr_q.push_back({bank[0], 14'(i), d});
    end
  endtask

  task automatic push_disp(input int bank, input int len, input int last);
    disp_q.push_back({bank[0], 15'(len), last[0]});
  endtask

  task automatic pulse_done();
    @(posedge clk);
    #1 man_done = 1'b1;
    @(posedge clk);
    #1 man_done = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while ((wr_q.size() != 0 || disp_q.size() != 0) && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(name, 32'(wr_q.size() + disp_q.size()), 32'd0);
  endtask

  task automatic wait_disp_left(input int left, input int budget);
    int k = 0;
    while (disp_q.size() > left && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("disp_wait", 32'(disp_q.size()), 32'(left));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wren"}, 32'(bus.bram_wren), 32'd0);
    check({tag, "_wrbank"}, 32'(bus.bram_wrbank), 32'd0);
    check({tag, "_wraddr"}, 32'(bus.bram_wraddr), 32'd0);
    check({tag, "_wrdata"}, 32'(bus.bram_wrdata), 32'd0);
    check({tag, "_start"}, 32'(bus.proc_start), 32'd0);
    check({tag, "_pbank"}, 32'(bus.proc_bank), 32'd0);
    check({tag, "_plen"}, 32'(bus.proc_len), 32'd0);
    check({tag, "_plast"}, 32'(bus.proc_last), 32'd0);
    check({tag, "_ovf"}, 32'(bus.ovf_sticky), 32'd0);
    check({tag, "_bank0"}, 32'(bus.dbg_bank0_st), 32'd0);
    check({tag, "_bank1"}, 32'(bus.dbg_bank1_st), 32'd0);
    check({tag, "_own"}, 32'(bus.dbg_wr_own), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, time %0t", $time);
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_data = 8'd0;
    bus.proc_ready = 1'b0;
    bus.ovf_clr = 1'b0;

    // Power-on reset state
    #1 rst = 1'b1;
    #2 check_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Full frame with a fast engine: alternate banks, short last tile, wrap to bank 0 addr 0
    eng_auto = 1'b1;
    bus.proc_ready = 1'b1;
    for (int t = 0; t < 6; t++) push_disp(t % 2, (t == 5) ? 16 : 64, (t == 5) ? 1 : 0);
    for (int t = 0; t < 6; t++) send_tile((t == 5) ? 16 : 64, t % 2, t, 1'b0);
    send_tile(1, 0, 99, 1'b0);
    idle(2);
    wait_drain("frame_drain", 200);
    check("frame_ovf", 32'(bus.ovf_sticky), 32'd0);
    idle(20);
    do_reset();

    // Engine stalled for three tiles: third tile dropped, then ordered dispatch
    bus.proc_ready = 1'b0;
    push_disp(0, 64, 0);
    push_disp(1, 64, 0);
    send_tile(64, 0, 40, 1'b0);
    send_tile(64, 1, 41, 1'b0);
    idle(1);
    check("stall_ovf_pre", 32'(bus.ovf_sticky), 32'd0);
    check("stall_bank0_full", 32'(bus.dbg_bank0_st), 32'd2);
    check("stall_bank1_full", 32'(bus.dbg_bank1_st), 32'd2);
    send_tile(64, -1, 42, 1'b0);
    idle(1);
    check("stall_ovf_set", 32'(bus.ovf_sticky), 32'd1);
    // Clear coinciding with a dropped pixel, then a lone clear
    @(posedge clk);
    #1 bus.pix_valid = 1'b1;
    bus.pix_data = 8'h5a;
    bus.ovf_clr = 1'b1;
    @(posedge clk);
    #1 bus.pix_valid = 1'b0;
    check("clr_vs_drop", 32'(bus.ovf_sticky), 32'd1);
    @(posedge clk);
    #1 bus.ovf_clr = 1'b0;
    check("clr_alone", 32'(bus.ovf_sticky), 32'd0);
    bus.proc_ready = 1'b1;
    wait_drain("stall_drain", 400);
    idle(20);
    do_reset();

    // Completion coinciding with the first pixel of a tile frees that bank for it
    eng_auto = 1'b0;
    bus.proc_ready = 1'b1;
    push_disp(0, 64, 0);
    push_disp(1, 64, 0);
    push_disp(0, 64, 0);
    send_tile(64, 0, 50, 1'b0);
    send_tile(64, 1, 51, 1'b0);
    send_tile(64, 0, 52, 1'b1);
    idle(2);
    wait_disp_left(1, 50);
    check("same_bank0_full", 32'(bus.dbg_bank0_st), 32'd2);
    check("same_bank1_busy", 32'(bus.dbg_bank1_st), 32'd3);
    pulse_done();
    wait_drain("same_drain", 50);
    pulse_done();
    idle(2);
    check("same_ovf", 32'(bus.ovf_sticky), 32'd0);
    check("same_bank0_empty", 32'(bus.dbg_bank0_st), 32'd0);
    check("same_bank1_empty", 32'(bus.dbg_bank1_st), 32'd0);
    do_reset();

    // Reset mid-tile with a tile in flight; stray completion afterwards is ignored
    push_disp(0, 64, 0);
    send_tile(64, 0, 60, 1'b0);
    send_tile(40, 1, 61, 1'b0);
    idle(2);
    wait_drain("mid_pre_drain", 50);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    pulse_done();
    idle(3);
    check("stray_bank0", 32'(bus.dbg_bank0_st), 32'd0);
    check("stray_bank1", 32'(bus.dbg_bank1_st), 32'd0);
    send_tile(1, 0, 70, 1'b0);
    idle(2);
    wait_drain("mid_post_drain", 20);
    check("mid_ovf", 32'(bus.ovf_sticky), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/img_bank_sched.md
IMG_BANK_SCHED -- requirements
Module: img_bank_sched

Interface
REQ-001 Parameter TILE_PIX, default 16384: pixels per full tile; one bank holds one tile.
REQ-002 Parameter FRAME_PIX, default 360960: pixels per frame; last tile of a frame may be partial (512 px at defaults).
REQ-003 s_axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-004 s_axi_areset  in  1  asynchronous, active-high reset.
REQ-005 pix_valid  in  1  input pixel strobe from denoise stream; no backpressure.
REQ-006 pix_data  in  8  input pixel value.
REQ-007 bram_wren  out  1  image BRAM write enable.
REQ-008 bram_wrbank  out  1  bank select for the write (0/1).
REQ-009 bram_wraddr  out  14  pixel address within bank.
REQ-010 bram_wrdata  out  8  write data.
REQ-011 proc_ready  in  1  enhancement engine idle, may accept a tile.
REQ-012 proc_start  out  1  one-cycle pulse dispatching a tile.
REQ-013 proc_bank  out  1  bank of dispatched tile; stable from proc_start until next proc_start.
REQ-014 proc_len  out  15  pixel count of dispatched tile, 1..TILE_PIX; stable with proc_bank.
REQ-015 proc_last  out  1  dispatched tile ends the frame; stable with proc_bank.
REQ-016 proc_done  in  1  one-cycle pulse: engine finished the in-flight tile.
REQ-017 ovf_sticky  out  1  set when a pixel is dropped; cleared by ovf_clr.
REQ-018 ovf_clr  in  1  clears ovf_sticky.

Function
REQ-019 Each bank SHALL hold state EMPTY, FILLING, FULL or BUSY; writer SHALL hold state OWN (owns a FILLING bank) or DROP (no bank).
REQ-020 Counters: tile pixel counter tcnt (0..TILE_PIX-1), frame pixel counter fcnt (19 bits, 0..FRAME_PIX-1); both advance on every pix_valid, whether written or dropped.
REQ-021 Tile end = pix_valid with tcnt==TILE_PIX-1 or fcnt==FRAME_PIX-1; on tile end tcnt->0; on fcnt==FRAME_PIX-1 fcnt->0.
REQ-022 In OWN, each pix_valid SHALL produce bram_wren=1 the next cycle with bram_wrbank=owned bank, bram_wraddr=tcnt, bram_wrdata=pix_data (1-cycle registered latency).
REQ-023 On tile end in OWN: owned bank -> FULL, latching length tcnt+1 and last=(fcnt==FRAME_PIX-1).
REQ-024 Bank claim only at tile start (tcnt==0 with pix_valid): if the other bank (or either, in DROP) is EMPTY, claim it (FILLING), lower index preferred when both EMPTY; else DROP for the whole tile.
REQ-025 In DROP, pix_valid SHALL yield bram_wren=0 and set ovf_sticky the next cycle; a dropped tile is never dispatched.
REQ-026 Dispatch: when no tile in flight, proc_ready=1 and a bank is FULL, assert proc_start for one cycle, bank -> BUSY; if both FULL, the one filled first goes first.
REQ-027 At most one tile in flight; proc_start SHALL not re-assert until proc_done received.
REQ-028 proc_done: BUSY bank -> EMPTY; that bank is claimable at the next tile start, including a tile start in the same cycle.
REQ-029 proc_done with no tile in flight SHALL be ignored.
REQ-030 ovf_clr and a drop in the same cycle: ovf_sticky stays 1 (set wins).
REQ-031 FULL->dispatch and tile-end->FULL on the same bank never coincide; a tile ending while other bank dispatches SHALL both complete in that cycle.

Reset
REQ-032 On s_axi_areset=1, immediately: banks EMPTY, writer DROP with claim pending at next pixel, tcnt=0, fcnt=0, bram_wren=0, bram_wrbank=0, bram_wraddr=0, bram_wrdata=0, proc_start=0, proc_bank=0, proc_len=0, proc_last=0, ovf_sticky=0.
REQ-033 Reset mid-tile or mid-dispatch SHALL discard all tile state; the first pix_valid after release is frame pixel 0 and claims bank 0.
REQ-034 proc_done arriving after reset for a pre-reset dispatch SHALL be ignored (REQ-029).

Verification
REQ-035 Reset release, proc_ready=1, 16384 contiguous pixels -> bram_wraddr 0..16383 on bank 0, then one proc_start with proc_bank=0, proc_len=16384, proc_last=0.
REQ-036 Full frame 360960 px, engine done in <16384 cycles -> 22 full tiles alternating banks 0/1, 23rd dispatch proc_len=512, proc_last=1; fcnt wraps, next pixel writes bank address 0; ovf_sticky=0.
REQ-037 proc_ready=0 for 3 tiles -> tiles 0,1 FULL, tile 2 fully dropped, bram_wren=0, ovf_sticky=1; after proc_ready=1 dispatches bank 0 then (after proc_done) bank 1.
REQ-038 proc_done on same cycle as tile-2 first pixel with both banks otherwise occupied -> freed bank claimed, tile 2 written, no overflow.
REQ-039 ovf_clr with simultaneous dropped pixel -> ovf_sticky remains 1; ovf_clr alone next cycle -> 0.
REQ-040 Reset asserted at pixel 5000 of tile 1 with tile 0 BUSY -> all outputs to reset values; stray proc_done ignored; next pixel writes bank 0 address 0.
